// File: rtl/fc_scm_responder_if.sv
// fc_scm_responder_if: request/grant/r_valid bus between the FC demux SCM
// port (master) and the SCM responder (slave).
interface fc_scm_responder_if;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_opc_o;

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );
endinterface

// File: rtl/fc_scm_responder.sv
// fc_scm_responder: responder end of the FC private SCM channel. Serves
// single-word reads and byte-enabled writes into a 2**ADDR_WIDTH x 32
// register-file memory, grants after WAIT_CYCLES wait states and returns
// one registered response per grant.
// Optional feature macro: FC_SCM_CLEAR_EN -- when defined, an INIT state
// zeroes the whole memory (one word per cycle) after every reset.
module fc_scm_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fc_scm_responder_if.slave bus,
    output logic              busy_o
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);

    logic [31:0]           r_mem [DEPTH];
    logic [2:0]            r_cnt;
    logic                  r_valid;
    logic [31:0]           r_rdata;
    logic                  r_opc;

    logic                  w_ready;
    logic                  w_gnt;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_memWr;
    logic                  w_clrWr;
    logic [ADDR_WIDTH-1:0] w_clrIdx;
    logic                  w_unused;

`ifdef FC_SCM_CLEAR_EN
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_initIdx;

    // INIT walks every word index once after reset, then hands over to READY
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_INIT;
            r_initIdx <= '0;
        end else if (r_state == ST_INIT) begin
            r_initIdx <= r_initIdx + 1'b1;
            if (&r_initIdx) begin
                r_state <= ST_READY;
            end
        end
    end

    assign w_ready  = (r_state == ST_READY);
    assign busy_o   = (r_state == ST_INIT);
    assign w_clrWr  = (r_state == ST_INIT);
    assign w_clrIdx = r_initIdx;
`else
    assign w_ready  = 1'b1;
    assign busy_o   = 1'b0;
    assign w_clrWr  = 1'b0;
    assign w_clrIdx = '0;
`endif

    // The low address bits select a byte within the word and play no role
    assign w_unused = ^bus.add_i[1:0];

    assign w_hit   = (bus.add_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_index = bus.add_i[ADDR_WIDTH+1:2];
    assign w_gnt   = bus.req_i && w_ready && (r_cnt == WAIT_CNT);
    assign w_memWr = w_gnt && w_hit && !bus.wen_i;

    // Wait-state counter: counts pending request cycles, restarts on grant or idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_ready && bus.req_i && !w_gnt) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Memory update: INIT clearing or a granted hit write; nothing lands while reset is high
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_clrWr) begin
                r_mem[w_clrIdx] <= '0;
            end else if (w_memWr) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.be_i[k]) begin
                        r_mem[w_index][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Response register: one valid pulse after each grant, data/error held until the next one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_opc   <= 1'b0;
        end else begin
            r_valid <= w_gnt;
            if (w_gnt) begin
                if (!w_hit) begin
                    r_rdata <= '0;
                    r_opc   <= 1'b1;
                end else if (bus.wen_i) begin
                    r_rdata <= r_mem[w_index];
                    r_opc   <= 1'b0;
                end else begin
                    r_rdata <= '0;
                    r_opc   <= 1'b0;
                end
            end
        end
    end

    assign bus.gnt_o     = w_gnt;
    assign bus.r_valid_o = r_valid;
    assign bus.r_rdata_o = r_rdata;
    assign bus.r_opc_o   = r_opc;
endmodule

// File: tb/tb_fc_scm_responder.sv
// tb_fc_scm_responder: scoreboard bench for fc_scm_responder. dut0 runs with
// no wait states, dut3 with three; both use a 16-word memory. Honours
// FC_SCM_CLEAR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fc_scm_responder;
    logic clk = 1'b0;
    logic rst;
    logic busy0;
    logic busy3;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] expQ [$];
    logic [32:0] expV;
    logic [32:0] actV;

`ifdef FC_SCM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    always #5 clk = ~clk;

    fc_scm_responder_if bus0 ();
    fc_scm_responder_if bus3 ();

    fc_scm_responder #(
        .ADDR_WIDTH (4),
        .BASE_ADDR  (32'h1C00_0000),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0.slave),
        .busy_o(busy0)
    );

    fc_scm_responder #(
        .ADDR_WIDTH (4),
        .BASE_ADDR  (32'h1C00_0000),
        .WAIT_CYCLES(3)
    ) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3.slave),
        .busy_o(busy3)
    );

    // Oldest expected response {opc, rdata}; X when nothing was expected
    function automatic logic [32:0] popExp();
        if (expQ.size() == 0) return {33{1'bx}};
        return expQ.pop_front();
    endfunction

    task automatic drive0(input logic req, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] be);
        bus0.req_i   = req;
        bus0.add_i   = addr;
        bus0.wen_i   = wen;
        bus0.wdata_i = wdata;
        bus0.be_i    = be;
    endtask

    task automatic drive3(input logic req, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] be);
        bus3.req_i   = req;
        bus3.add_i   = addr;
        bus3.wen_i   = wen;
        bus3.wdata_i = wdata;
        bus3.be_i    = be;
    endtask

    // Waits (bounded) until both responders leave initialisation
    task automatic waitReady();
        int n = 0;
        while ((busy0 !== 1'b0 || busy3 !== 1'b0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy0 !== 1'b0 || busy3 !== 1'b0) begin
            checks++; errors++;
            $display("[TB] FAIL ready_timeout busy0=%b busy3=%b expected 0", busy0, busy3);
        end
    endtask

    // Runs one dut3 transaction and records when grant / responses appear
    task automatic runOp3(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                          output int gntCyc, output int validCyc, output int pulses,
                          output logic [32:0] resp);
        gntCyc = 0; validCyc = 0; pulses = 0; resp = '0;
        drive3(1'b1, addr, wen, wdata, 4'hF);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (bus3.r_valid_o === 1'b1) begin
                pulses++;
                validCyc = cyc;
                resp = {bus3.r_opc_o, bus3.r_rdata_o};
            end
            if (bus3.gnt_o === 1'b1 && gntCyc == 0) gntCyc = cyc;
            @(posedge clk); #1;
            if (gntCyc != 0) drive3(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        drive3(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.r_valid_o !== 1'b0 || bus0.r_rdata_o !== 32'h0 || bus0.r_opc_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp valid=%b rdata=%h opc=%b expected 0/0/0",
                     bus0.r_valid_o, bus0.r_rdata_o, bus0.r_opc_o);
        end
        checks++;
        if (bus0.gnt_o !== 1'b0 || bus3.r_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_gnt gnt0=%b valid3=%b expected 0/0", bus0.gnt_o, bus3.r_valid_o);
        end
        checks++;
        if (busy0 !== EXP_BUSY) begin
            errors++;
            $display("[TB] FAIL reset_busy busy=%b expected %b", busy0, EXP_BUSY);
        end
        @(posedge clk); #1;
    endtask

`ifdef FC_SCM_CLEAR_EN
    task automatic test_init();
        drive0(1'b1, 32'h1C00_0000, 1'b1, 32'h0, 4'h0);
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (busy0 !== 1'b1 || bus0.gnt_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL init_cycle%0d busy=%b gnt=%b expected 1/0", i, busy0, bus0.gnt_o);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || bus0.gnt_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_done busy=%b gnt=%b expected 0/1", busy0, bus0.gnt_o);
        end
        expQ.push_back({1'b0, 32'h0});
        for (int w = 1; w <= 16; w++) begin
            @(posedge clk); #1;
            if (w < 16) drive0(1'b1, 32'h1C00_0000 + 32'(4 * w), 1'b1, 32'h0, 4'h0);
            else        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
            checks++;
            expV = popExp();
            actV = {bus0.r_opc_o, bus0.r_rdata_o};
            if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
                errors++;
                $display("[TB] FAIL init_clear_word%0d valid=%b got=%h expected=%h", w - 1,
                         bus0.r_valid_o, actV, expV);
            end
            if (w < 16) begin
                @(negedge clk);
                if (bus0.gnt_o === 1'b1) expQ.push_back({1'b0, 32'h0});
            end
        end
    endtask
`endif

    task automatic test_write_read();
        drive0(1'b1, 32'h1C00_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        checks++;
        if (bus0.gnt_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_gnt_same_cycle gnt=%b expected 1", bus0.gnt_o);
        end
        expQ.push_back({1'b0, 32'h0});
        @(posedge clk); #1;
        drive0(1'b1, 32'h1C00_0010, 1'b1, 32'h0, 4'h0);
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL wr_resp valid=%b got=%h expected=%h", bus0.r_valid_o, actV, expV);
        end
        @(negedge clk);
        checks++;
        if (bus0.gnt_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rd_gnt_same_cycle gnt=%b expected 1", bus0.gnt_o);
        end
        expQ.push_back({1'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL rd_resp valid=%b got=%h expected=%h", bus0.r_valid_o, actV, expV);
        end
        @(posedge clk); #1;
        checks++;
        if (bus0.r_valid_o !== 1'b0 || bus0.r_rdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL rd_hold valid=%b rdata=%h expected 0/deadbeef",
                     bus0.r_valid_o, bus0.r_rdata_o);
        end
    endtask

    task automatic test_partial_write();
        drive0(1'b1, 32'h1C00_0010, 1'b0, 32'h1122_3344, 4'b0101);
        expQ.push_back({1'b0, 32'h0});
        @(posedge clk); #1;
        drive0(1'b1, 32'h1C00_0010, 1'b1, 32'h0, 4'h0);
        expQ.push_back({1'b0, 32'hDE22_BE44});
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL partial_wr_resp valid=%b got=%h expected=%h", bus0.r_valid_o, actV, expV);
        end
        @(posedge clk); #1;
        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL partial_rd_data valid=%b got=%h expected=%h", bus0.r_valid_o, actV, expV);
        end
    endtask

    task automatic test_wait_states();
        int          gntCyc;
        int          validCyc;
        int          pulses;
        logic [32:0] resp;
        waitReady();
        expQ.push_back({1'b0, 32'h0});
        runOp3(32'h1C00_0020, 1'b0, 32'hCAFE_F00D, gntCyc, validCyc, pulses, resp);
        checks++;
        expV = popExp();
        if (gntCyc != 4 || validCyc != 5 || pulses != 1 || resp !== expV) begin
            errors++;
            $display("[TB] FAIL wait_write gnt@%0d valid@%0d pulses=%0d got=%h expected gnt@4 valid@5 pulses=1 %h",
                     gntCyc, validCyc, pulses, resp, expV);
        end
        // Request abandoned before grant: the wait count must start over
        drive3(1'b1, 32'h1C00_0020, 1'b1, 32'h0, 4'h0);
        repeat (2) begin @(posedge clk); #1; end
        drive3(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        @(posedge clk); #1;
        expQ.push_back({1'b0, 32'hCAFE_F00D});
        runOp3(32'h1C00_0020, 1'b1, 32'h0, gntCyc, validCyc, pulses, resp);
        checks++;
        expV = popExp();
        if (gntCyc != 4 || validCyc != 5 || pulses != 1 || resp !== expV) begin
            errors++;
            $display("[TB] FAIL wait_read gnt@%0d valid@%0d pulses=%0d got=%h expected gnt@4 valid@5 pulses=1 %h",
                     gntCyc, validCyc, pulses, resp, expV);
        end
    endtask

    task automatic test_miss();
        logic [31:0] addrs [3];
        logic        wens  [3];
        addrs = '{32'h2000_0000, 32'h2000_0010, 32'h1C00_0010};
        wens  = '{1'b1, 1'b0, 1'b1};
        expQ.push_back({1'b1, 32'h0});
        expQ.push_back({1'b1, 32'h0});
        expQ.push_back({1'b0, 32'hDE22_BE44});
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive0(1'b1, addrs[i], wens[i], 32'h5555_5555, 4'hF);
            else       drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
            if (i < 3) begin
                @(negedge clk);
                checks++;
                if (bus0.gnt_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL miss_gnt%0d gnt=%b expected 1", i, bus0.gnt_o);
                end
            end
            if (i > 0) begin
                checks++;
                expV = popExp();
                actV = {bus0.r_opc_o, bus0.r_rdata_o};
                if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
                    errors++;
                    $display("[TB] FAIL miss_resp%0d valid=%b got=%h expected=%h", i - 1,
                             bus0.r_valid_o, actV, expV);
                end
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, 32'h1C00_0030, 1'b0, 32'h0BAD_F00D, 4'hF);
        expQ.push_back({1'b0, 32'h0});
        @(posedge clk); #1;
        drive0(1'b1, 32'h1C00_0030, 1'b1, 32'h0, 4'h0);
        expQ.push_back({1'b0, 32'h0BAD_F00D});
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL b2b_wr_resp valid=%b got=%h expected=%h", bus0.r_valid_o, actV, expV);
        end
        @(posedge clk); #1;
        drive0(1'b1, 32'h1C00_0030, 1'b0, 32'h1234_5678, 4'hF);
        rst = 1'b1;
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL b2b_raw_data valid=%b got=%h expected=%h", bus0.r_valid_o, actV, expV);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        checks++;
        if (bus0.r_valid_o !== 1'b0 || bus0.r_rdata_o !== 32'h0 || bus0.r_opc_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_reset_suppress valid=%b rdata=%h opc=%b expected 0/0/0",
                     bus0.r_valid_o, bus0.r_rdata_o, bus0.r_opc_o);
        end
        waitReady();
        drive0(1'b1, 32'h1C00_0030, 1'b1, 32'h0, 4'h0);
`ifdef FC_SCM_CLEAR_EN
        expQ.push_back({1'b0, 32'h0});
`else
        expQ.push_back({1'b0, 32'h0BAD_F00D});
`endif
        @(posedge clk); #1;
        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        checks++;
        expV = popExp();
        actV = {bus0.r_opc_o, bus0.r_rdata_o};
        if (bus0.r_valid_o !== 1'b1 || actV !== expV) begin
            errors++;
            $display("[TB] FAIL b2b_discarded_write valid=%b got=%h expected=%h",
                     bus0.r_valid_o, actV, expV);
        end
        @(posedge clk); #1;
        checks++;
        if (bus0.r_valid_o !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_tail valid=%b pending=%0d expected 0/0", bus0.r_valid_o, expQ.size());
        end
    endtask

    initial begin
        $display("[TB] fc_scm_responder bench start");
        test_reset();
`ifdef FC_SCM_CLEAR_EN
        test_init();
`endif
        test_write_read();
        test_partial_write();
        test_wait_states();
        test_miss();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
